// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: arms an upstream read buffer and queues its bytes in a
// first-word fall-through FIFO. Optional drop counter: SERIAL_RX_FIFO_OVF_COUNT_EN.
// Ports: sys_clk/rst (sync, active-high); enable, buf_busy, buf_data_ready,
// buf_data in / buf_start out to the upstream buffer; rd_en in / rd_data,
// rd_valid, full, count out on the read side; clr_ovf in / overflow,
// ovf_count out for dropped-byte reporting.
module serial_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    buf_busy,
  input  logic                    buf_data_ready,
  input  logic [DATA_WIDTH-1:0]   buf_data,
  output logic                    buf_start,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    clr_ovf,
  output logic                    overflow,
  output logic [7:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic rdy_q;
  logic wr_ev;
  logic pop;
  logic push;
  logic drop;

  // One write per rising edge of data-ready, however long it stays high.
  assign wr_ev = buf_data_ready & ~rdy_q;

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_en & rd_valid;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push     = wr_ev & (~full | pop);
  assign drop     = wr_ev & full & ~pop;

  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
  assign buf_start = (state == ARM);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= buf_data_ready;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default: ;
      endcase
      if (clr_ovf)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= buf_data;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (enable & ~buf_busy & ~full)
          state_nxt = ARM;
      ARM:
        state_nxt = WAIT_BUSY;
      WAIT_BUSY:
        if (buf_busy | wr_ev)
          state_nxt = WAIT_DONE;
      WAIT_DONE:
        if (~buf_busy)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

`ifdef SERIAL_RX_FIFO_OVF_COUNT_EN
  always_ff @(posedge sys_clk) begin
    if (rst | clr_ovf)
      ovf_count <= 8'd0;
    else if (drop && ovf_count != 8'hFF)
      ovf_count <= ovf_count + 8'd1;
  end
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: randomized bench for serial_rx_fifo with a
// queue-based reference model of the FIFO and overflow reporting.
module tb_serial_rx_fifo;

  localparam int DEPTH = 16;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       buf_busy = 1'b0;
  logic       buf_data_ready = 1'b0;
  logic [7:0] buf_data = 8'd0;
  logic       buf_start;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] count;
  logic       clr_ovf = 1'b0;
  logic       overflow;
  logic [7:0] ovf_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_ovfc = 0;
  bit         prev_rdy = 1'b0;

  always #5 sys_clk = ~sys_clk;

  serial_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .enable(enable),
    .buf_busy(buf_busy),
    .buf_data_ready(buf_data_ready),
    .buf_data(buf_data),
    .buf_start(buf_start),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .count(count),
    .clr_ovf(clr_ovf),
    .overflow(overflow),
    .ovf_count(ovf_count)
  );

  // Advance one clock; the model consumes the inputs seen at this edge.
  task automatic tick();
    bit ev;
    bit pop;
    bit was_full;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ovfc = 0;
      prev_rdy = 1'b0;
    end else begin
      ev = buf_data_ready && !prev_rdy;
      pop = rd_en && (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      if (pop)
        void'(mq.pop_front());
      if (ev) begin
        if (!was_full || pop) begin
          mq.push_back(buf_data);
        end else begin
          m_ovf = 1'b1;
`ifdef SERIAL_RX_FIFO_OVF_COUNT_EN
          if (m_ovfc < 255)
            m_ovfc++;
`endif
        end
      end
      if (clr_ovf) begin
        m_ovf = 1'b0;
        m_ovfc = 0;
      end
      prev_rdy = buf_data_ready;
    end
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] exp_head();
    return (mq.size() > 0) ? mq[0] : 8'd0;
  endfunction

  // Plays the upstream buffer for one byte once it has been armed.
  task automatic capture(input logic [7:0] b, input bit drop_en);
    int n = 0;
    while (!buf_start && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (buf_start !== 1'b1) begin
      fails++;
      $display("FAIL capture_arm: buf_start=%b required 1", buf_start);
    end
    tick();
    if (drop_en)
      enable = 1'b0;
    buf_busy = 1'b1;
    tick();
    tick();
    buf_data = b;
    buf_data_ready = 1'b1;
    buf_busy = 1'b0;
    tick();
    buf_data_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: count=%0d rd_valid=%b full=%b required 0 0 0",
               count, rd_valid, full);
    end
    tests++;
    if (rd_data !== 8'd0 || buf_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: rd_data=%h buf_start=%b required 00 0",
               rd_data, buf_start);
    end
    tests++;
    if (overflow !== 1'b0 || ovf_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_ovf: overflow=%b ovf_count=%0d required 0 0",
               overflow, ovf_count);
    end
  endtask

  task automatic test_arm();
    enable = 1'b1;
    tests++;
    if (buf_start !== 1'b0) begin
      fails++;
      $display("FAIL arm_before: buf_start=%b required 0", buf_start);
    end
    tick();
    tests++;
    if (buf_start !== 1'b1) begin
      fails++;
      $display("FAIL arm_pulse: buf_start=%b required 1", buf_start);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (buf_start !== 1'b0) begin
        fails++;
        $display("FAIL arm_width: cycle %0d buf_start=%b required 0", i, buf_start);
      end
    end
    buf_busy = 1'b1;
    tick();
    enable = 1'b0;
    buf_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_multi();
    logic [7:0] exp [3];
    exp[0] = 8'h3A;
    exp[1] = 8'h71;
    exp[2] = 8'hF0;
    enable = 1'b1;
    capture(exp[0], 1'b0);
    capture(exp[1], 1'b0);
    capture(exp[2], 1'b1);
    tests++;
    if (count !== 5'd3) begin
      fails++;
      $display("FAIL multi_count: count=%0d required 3", count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (buf_start !== 1'b0) begin
        fails++;
        $display("FAIL multi_no_rearm: cycle %0d buf_start=%b required 0", i, buf_start);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_data !== exp[i] || rd_valid !== 1'b1) begin
        fails++;
        $display("FAIL multi_pop%0d: rd_data=%h rd_valid=%b required %h 1",
                 i, rd_data, rd_valid, exp[i]);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    tests++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      fails++;
      $display("FAIL multi_empty: rd_valid=%b count=%0d required 0 0", rd_valid, count);
    end
  endtask

  task automatic test_hold();
    buf_data = 8'h55;
    buf_data_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      tick();
    buf_data_ready = 1'b0;
    tick();
    tests++;
    if (count !== 5'd1 || rd_data !== 8'h55) begin
      fails++;
      $display("FAIL hold_single: count=%0d rd_data=%h required 1 55", count, rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp_c;
    for (int i = 0; i < DEPTH; i++) begin
      buf_data = 8'($urandom);
      buf_data_ready = 1'b1;
      tick();
      buf_data_ready = 1'b0;
      tick();
    end
    tests++;
    if (full !== 1'b1 || count !== 5'd16) begin
      fails++;
      $display("FAIL full_flag: full=%b count=%0d required 1 16", full, count);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (buf_start !== 1'b0) begin
        fails++;
        $display("FAIL full_no_arm: cycle %0d buf_start=%b required 0", i, buf_start);
      end
    end
    enable = 1'b0;
    buf_data = 8'hEE;
    buf_data_ready = 1'b1;
    tick();
    buf_data_ready = 1'b0;
    tick();
`ifdef SERIAL_RX_FIFO_OVF_COUNT_EN
    exp_c = 8'd1;
`else
    exp_c = 8'd0;
`endif
    tests++;
    if (overflow !== 1'b1 || ovf_count !== exp_c) begin
      fails++;
      $display("FAIL drop_flag: overflow=%b ovf_count=%0d required 1 %0d",
               overflow, ovf_count, exp_c);
    end
    tests++;
    if (count !== 5'd16 || rd_data !== exp_head()) begin
      fails++;
      $display("FAIL drop_unchanged: count=%0d rd_data=%h required 16 %h",
               count, rd_data, exp_head());
    end
    buf_data = 8'hC3;
    buf_data_ready = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    buf_data_ready = 1'b0;
    tick();
    tests++;
    if (count !== 5'd16 || rd_data !== exp_head() || ovf_count !== exp_c) begin
      fails++;
      $display("FAIL full_rw: count=%0d rd_data=%h ovf_count=%0d required 16 %h %0d",
               count, rd_data, ovf_count, exp_head(), exp_c);
    end
    for (int i = 0; i < 260; i++) begin
      buf_data_ready = 1'b1;
      tick();
      buf_data_ready = 1'b0;
      tick();
    end
`ifdef SERIAL_RX_FIFO_OVF_COUNT_EN
    exp_c = 8'd255;
`else
    exp_c = 8'd0;
`endif
    tests++;
    if (ovf_count !== exp_c || ovf_count !== 8'(m_ovfc)) begin
      fails++;
      $display("FAIL ovf_saturate: ovf_count=%0d required %0d", ovf_count, exp_c);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests++;
    if (overflow !== 1'b0 || ovf_count !== 8'd0) begin
      fails++;
      $display("FAIL clr_ovf: overflow=%b ovf_count=%0d required 0 0", overflow, ovf_count);
    end
    while (mq.size() > 0) begin
      tests++;
      if (rd_data !== exp_head()) begin
        fails++;
        $display("FAIL drain: rd_data=%h required %h", rd_data, exp_head());
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: rd_valid=%b required 0", rd_valid);
    end
  endtask

  task automatic test_random();
    int writes = 0;
    logic [4:0] exp_n;
    for (int i = 0; i < 400; i++) begin
      buf_data_ready = ($urandom_range(1, 0) == 1);
      buf_data = 8'($urandom);
      if (i < 200)
        rd_en = ($urandom_range(3, 0) == 0);
      else
        rd_en = ($urandom_range(3, 0) != 0);
      if (buf_data_ready && !prev_rdy)
        writes++;
      tick();
      exp_n = 5'(mq.size());
      tests++;
      if (count !== exp_n || rd_valid !== (mq.size() > 0) ||
          full !== (mq.size() == DEPTH)) begin
        fails++;
        $display("FAIL rand_count: cycle %0d count=%0d valid=%b full=%b required %0d",
                 i, count, rd_valid, full, exp_n);
      end
      tests++;
      if (rd_data !== exp_head() || overflow !== m_ovf) begin
        fails++;
        $display("FAIL rand_data: cycle %0d rd_data=%h ovf=%b required %h %b",
                 i, rd_data, overflow, exp_head(), m_ovf);
      end
    end
    buf_data_ready = 1'b0;
    rd_en = 1'b0;
    tick();
    tests++;
    if (writes < 40) begin
      fails++;
      $display("FAIL rand_coverage: writes=%0d required at least 40", writes);
    end
    while (mq.size() > 0) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++)
      capture(8'($urandom), 1'b0);
    while (!buf_start && n < 20) begin
      tick();
      n++;
    end
    tick();
    buf_busy = 1'b1;
    tick();
    tick();
    tests++;
    if (count !== 5'd5) begin
      fails++;
      $display("FAIL mid_count: count=%0d required 5", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    buf_busy = 1'b0;
    tests++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || buf_start !== 1'b0 || rd_data !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d valid=%b start=%b data=%h required 0 0 0 00",
               count, rd_valid, buf_start, rd_data);
    end
    tick();
    tests++;
    if (buf_start !== 1'b1) begin
      fails++;
      $display("FAIL mid_idle: buf_start=%b required 1", buf_start);
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_arm();
    test_multi();
    test_hold();
    test_full_overflow();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
